// File: rtl/uart_rx_fifo_if.sv
// UART receive FIFO bus: receiver-side push signals and register-side
// show-ahead read and status signals.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             rx_done;
  logic [WIDTH-1:0] rx_data;
  logic             rx_err;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_err;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overrun;
  logic             clr_overrun;
  logic [7:0]       err_cnt;

  modport master (
    output rx_done, rx_data, rx_err,
    output rd_en, clr_overrun,
    input  rd_data, rd_err, empty, full,
    input  almost_full, count, overrun,
    input  err_cnt
  );

  modport slave (
    input  rx_done, rx_data, rx_err,
    input  rd_en, clr_overrun,
    output rd_data, rd_err, empty, full,
    output almost_full, count, overrun,
    output err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with show-ahead read, watermark and overrun flag.
// UART_RX_FIFO_DROP_ERR_EN: discard error frames and count them in err_cnt.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 12
) (
  input  logic         clk,
  input  logic         rstN,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovr;
  logic [7:0]      ecnt;

  logic            is_full;
  logic            is_empty;
  logic            frame;
  logic            pop;
  logic            push;
  logic            lost;
  logic [WIDTH:0]  head;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic drop_err;
  assign drop_err = rstN & bus.rx_done & bus.rx_err;
  assign frame    = bus.rx_done & ~bus.rx_err;
`else
  assign frame    = bus.rx_done;
`endif

  assign pop  = rstN & bus.rd_en & ~is_empty;
  assign push = rstN & frame & (~is_full | pop);
  assign lost = frame & is_full & ~bus.rd_en;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.rx_err, bus.rx_data};
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: cnt <= cnt + 1'b1;
        pop && !push: cnt <= cnt - 1'b1;
        default:      cnt <= cnt;
      endcase
      // set wins over a coincident clear
      if (lost)                 ovr <= 1'b1;
      else if (bus.clr_overrun) ovr <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_ERR_EN
  always_ff @(posedge clk) begin
    if (!rstN)
      ecnt <= '0;
    else if (drop_err && ecnt != 8'hFF)
      ecnt <= ecnt + 8'd1;
  end
`else
  assign ecnt = '0;
`endif

  assign head            = mem[rd_ptr];
  assign bus.rd_data     = head[WIDTH-1:0];
  assign bus.rd_err      = head[WIDTH];
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (cnt >= CW'(AF_LEVEL));
  assign bus.count       = cnt;
  assign bus.overrun     = ovr;
  assign bus.err_cnt     = ecnt;
endmodule
